univ_shift_reg_p: RTL and testbench
===================================

# univ_shift_reg_p

Parametrised universal shift register with multi-cycle shift bursts. A WIDTH-bit register supports parallel load and six shift/rotate modes: logical shift left/right with serial fill, rotate left/right, arithmetic shift right, and hold. A `start`/`busy`/`done` handshake runs a counted burst of single-bit shifts, one per clock. It is the general-purpose shifter for serialisers, bit-stream alignment and test datapaths.

## Interface
- `WIDTH`, 8: register width, ≥2.
- `CNT_W`, 4: width of the burst count; maximum burst is 2^CNT_W−1 shifts.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load` in 1: parallel load request, honoured only when idle.
- `parallel_in` in WIDTH: data for `load`.
- `start` in 1: burst request, honoured only when idle and `load`=0.
- `mode` in 3: shift mode, sampled with `start`.
- `count` in CNT_W: number of shifts in the burst, sampled with `start`.
- `ser_in_l` in 1: fill bit entering at MSB (SHR).
- `ser_in_r` in 1: fill bit entering at LSB (SHL).
- `q` out WIDTH: register contents.
- `ser_out_l` out 1: equals `q[WIDTH-1]`, combinational from `q`.
- `ser_out_r` out 1: equals `q[0]`, combinational from `q`.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse at burst completion.

## Operation
- Modes:
  - 0 HOLD
  - 1 SHL: `q <= {q[W-2:0], ser_in_r}`
  - 2 SHR: `q <= {ser_in_l, q[W-1:1]}`
  - 3 ROL
  - 4 ROR
  - 5 ASR: MSB replicated
  - 6 and 7: reserved, behave as HOLD.
- FSM states: IDLE and RUN.
- IDLE, `load`=1: `q <= parallel_in`. `start` in the same cycle is dropped; `load` wins.
- IDLE, `start`=1, `load`=0: latch `mode`, latch `rem <= count`.
  - `count`≠0: go to RUN.
  - `count`=0: stay IDLE, assert `done` next cycle, `q` unchanged.
- RUN, each edge:
  - Apply one shift using the latched mode.
  - `rem <= rem-1`.
  - When `rem`==1, return to IDLE and assert `done` for the following cycle.
- Serial fill inputs are sampled live at every shift edge; they are not latched at `start`.
- `load`, `start`, `mode` and `count` are ignored while `busy`=1, with no queuing.
- `count` > WIDTH is legal; shifting continues past a full flush. Example: ROL by WIDTH returns the original value.
- Reserved mode in a burst: same timing as a real burst, `q` unchanged.

## Timing
- Reset values: `q`=0, `busy`=0, `done`=0, state IDLE, `rem`=0, latched mode=HOLD.
- Reset is asynchronous. Asserting `rst_n` mid-burst clears everything immediately; no `done` is produced for the aborted burst.
- Load latency: 1 cycle.
- Burst with `start` accepted at edge k and `count`=N>0:
  - shifts occur at edges k+1 … k+N;
  - `busy`=1 from after edge k through edge k+N;
  - `done`=1 for exactly the cycle after edge k+N;
  - `busy` and `done` are never high together.
- A new `start` is accepted at edge k+N+1, which is the `done` cycle. Back-to-back bursts therefore have one idle edge between them.
- `count`=0: `done` pulses the cycle after edge k; `busy` stays 0.
- All outputs are registered except `ser_out_l` and `ser_out_r`.

## Structure
- Shared package `shift_pkg`:
  - mode constants `SH_HOLD`, `SH_SHL`, `SH_SHR`, `SH_ROL`, `SH_ROR`, `SH_ASR`;
  - FSM state constants `ST_IDLE`, `ST_RUN`.
- Sub-module `shift_step`: combinational, parameterised by WIDTH. It maps (`q`, `mode`, `ser_in_l`, `ser_in_r`) to the next `q`. Top level holds the FSM, counter and registers.

## Test plan
- Reset, then `load`=1 with `parallel_in`=8'hA5 → `q`=8'hA5 after 1 edge; `busy`=0, `done`=0.
- From `q`=8'hA5, `start`, ROL, `count`=3 → `q` goes 4B, 96, 2D on successive edges; `busy` high 3 cycles; `done` pulses once, the cycle after the 3rd shift.
- From `q`=8'h90, ASR, `count`=2 → `q` goes C8 then E4.
- From `q`=8'h0F, SHL, `count`=4, `ser_in_r`=1 → `q`=8'hFF. Repeat with `ser_in_r`=0 → `q`=8'hF0.
- Edge cases:
  - `start` with `count`=0 → `done` pulse next cycle, `busy` never high, `q` unchanged.
  - `load` and `start` in the same cycle → load taken, no burst.
  - `load`=8'h00 pulsed mid-burst → ignored.
- `rst_n` low for 1 ns mid-burst, between edges → `q`=0, `busy`=0 immediately; no `done`. After release, a fresh `start` is accepted normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants for the universal shift register:
// shift mode encodings and burst FSM state encodings.
package shift_pkg;

    localparam logic [2:0] SH_HOLD = 3'd0;
    localparam logic [2:0] SH_SHL  = 3'd1;
    localparam logic [2:0] SH_SHR  = 3'd2;
    localparam logic [2:0] SH_ROL  = 3'd3;
    localparam logic [2:0] SH_ROR  = 3'd4;
    localparam logic [2:0] SH_ASR  = 3'd5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/univ_shift_reg_p_if.sv
// Control/data bundle of the universal shift register.
// master drives requests, slave is the shifter.
interface univ_shift_reg_p_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             load;
    logic [WIDTH-1:0] parallel_in;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] count;
    logic             ser_in_l;
    logic             ser_in_r;
    logic [WIDTH-1:0] q;
    logic             ser_out_l;
    logic             ser_out_r;
    logic             busy;
    logic             done;

    modport master (
        output load, parallel_in, start, mode, count,
        output ser_in_l, ser_in_r,
        input  q, ser_out_l, ser_out_r, busy, done
    );

    modport slave (
        input  load, parallel_in, start, mode, count,
        input  ser_in_l, ser_in_r,
        output q, ser_out_l, ser_out_r, busy, done
    );
endinterface

// File: rtl/shift_step.sv
// One single-bit shift step: maps the current register value
// and mode to the next value. Reserved modes hold.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] q_next
);

    // Select the shifted value for the requested mode
    always_comb begin
        q_next = q;
        case (mode)
            SH_SHL:  q_next = {q[WIDTH-2:0], ser_in_r};
            SH_SHR:  q_next = {ser_in_l, q[WIDTH-1:1]};
            SH_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            SH_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            SH_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_p.sv
// Universal shift register with counted shift bursts.
// Holds the IDLE/RUN FSM, burst counter and data register.
module univ_shift_reg_p
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    univ_shift_reg_p_if.slave bus
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_step;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q        (q_q),
        .mode     (mode_q),
        .ser_in_l (bus.ser_in_l),
        .ser_in_r (bus.ser_in_r),
        .q_next   (q_step)
    );

    // Next-state: load/start acceptance when idle, one shift per RUN edge
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        q_d     = q_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    q_d = bus.parallel_in;
                end else if (bus.start) begin
                    mode_d = bus.mode;
                    rem_d  = bus.count;
                    if (bus.count != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                q_d   = q_step;
                rem_d = rem_q - ONE;
                if (rem_q == ONE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register update with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            mode_q  <= SH_HOLD;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = done_q;
    assign bus.ser_out_l = q_q[WIDTH-1];
    assign bus.ser_out_r = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg_p.sv
// Scoreboard bench for univ_shift_reg_p: bursts push expected
// final value and busy length; a monitor checks them at done.
`timescale 1ns/1ps
module tb_univ_shift_reg_p;
    import shift_pkg::*;

    typedef struct {
        logic [7:0] q;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   npass = 0;
    int   ntot = 0;
    exp_t sb[$];

    univ_shift_reg_p_if #(.WIDTH(8), .CNT_W(4)) bus ();

    univ_shift_reg_p #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.load = 1'b1;
        bus.parallel_in = v;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        chk("load_q", 32'(bus.q), 32'(v));
        chk("load_busy", 32'(bus.busy), 0);
    endtask

    task automatic burst(input logic [2:0] m, input logic [3:0] n,
                         input logic [7:0] fin, input logic [7:0] mids[4],
                         input int nmid);
        exp_t e;
        e.q = fin;
        e.cyc = int'(n);
        sb.push_back(e);
        bus.start = 1'b1;
        bus.mode = m;
        bus.count = n;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mode = SH_HOLD;
        bus.count = '0;
        for (int j = 1; j <= int'(n); j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j <= nmid) chk("mid_q", 32'(bus.q), 32'(mids[j-1]));
        end
    endtask

    task automatic monitor();
        int bcnt = 0;
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                bcnt = 0;
                continue;
            end
            if (bus.busy) bcnt++;
            if (bus.done) begin
                chk("done_busy_excl", 32'(bus.busy), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_q", 32'(bus.q), 32'(e.q));
                    chk("sb_busy_cycles", 32'(bcnt), 32'(e.cyc));
                end
                bcnt = 0;
            end
        end
    endtask

    initial begin
        logic [7:0] nm[4];
        nm = '{8'h00, 8'h00, 8'h00, 8'h00};
        bus.load = 1'b0;
        bus.parallel_in = '0;
        bus.start = 1'b0;
        bus.mode = SH_HOLD;
        bus.count = '0;
        bus.ser_in_l = 1'b0;
        bus.ser_in_r = 1'b0;
        fork
            monitor();
        join_none

        #12;
        chk("rst_q", 32'(bus.q), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", 32'(bus.done), 0);

        do_load(8'hA5);
        chk("ser_out_l", 32'(bus.ser_out_l), 1);
        chk("ser_out_r", 32'(bus.ser_out_r), 1);
        chk("load_done", 32'(bus.done), 0);
        burst(SH_ROL, 4'd3, 8'h2D, '{8'h4B, 8'h96, 8'h2D, 8'h00}, 3);

        do_load(8'h90);
        burst(SH_ASR, 4'd2, 8'hE4, '{8'hC8, 8'hE4, 8'h00, 8'h00}, 2);

        do_load(8'h0F);
        bus.ser_in_r = 1'b1;
        burst(SH_SHL, 4'd4, 8'hFF, nm, 0);
        do_load(8'h0F);
        bus.ser_in_r = 1'b0;
        burst(SH_SHL, 4'd4, 8'hF0, nm, 0);

        burst(SH_ROL, 4'd0, 8'hF0, nm, 0);
        @(negedge clk);

        bus.load = 1'b1;
        bus.parallel_in = 8'h3C;
        bus.start = 1'b1;
        bus.mode = SH_ROL;
        bus.count = 4'd5;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        bus.start = 1'b0;
        bus.mode = SH_HOLD;
        bus.count = '0;
        chk("collide_q", 32'(bus.q), 32'h3C);
        chk("collide_busy", 32'(bus.busy), 0);
        @(negedge clk);
        chk("collide_busy2", 32'(bus.busy), 0);
        chk("collide_done", 32'(bus.done), 0);

        do_load(8'h81);
        bus.ser_in_l = 1'b0;
        sb.push_back('{q: 8'h08, cyc: 4});
        bus.start = 1'b1;
        bus.mode = SH_SHR;
        bus.count = 4'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.load = 1'b1;
        bus.parallel_in = 8'h00;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        chk("midload_q", 32'(bus.q), 32'h40);
        chk("midload_busy", 32'(bus.busy), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);

        do_load(8'h81);
        burst(SH_ROR, 4'd10, 8'h60, nm, 0);
        burst(SH_ROL, 4'd8, 8'h60, nm, 0);
        burst(3'd7, 4'd3, 8'h60, nm, 0);

        bus.start = 1'b1;
        bus.mode = SH_SHL;
        bus.count = 4'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #0.5;
        chk("abort_q", 32'(bus.q), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        #0.5;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        do_load(8'h3C);
        bus.ser_in_r = 1'b1;
        burst(SH_SHL, 4'd1, 8'h79, nm, 0);
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
